core_control_fsm: RTL and testbench
===================================

CORE_CONTROL_FSM -- requirements
Module: core_control_fsm

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-005 SHALL have port imem_addr, output, 32 bits: fetch address, equal to pc.
REQ-006 SHALL have port imem_ready, input, 1 bit: fetch data valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-008 SHALL have port instruction, output, 32 bits: latched instruction register (IR) driving the ALU.
REQ-009 SHALL have port pc, output, 32 bits: current program counter.
REQ-010 SHALL have ports register_type_alu, immediate_type_alu, branch_enable, jal_enable, jalr_enable, lui_enable and auipc_enable, each output, 1 bit: ALU sub-unit enables.
REQ-011 SHALL have ports next_pc_valid, input, 1 bit, and next_pc, input, 32 bits: PC redirect from the ALU.
REQ-012 SHALL have port rd_write_enable, output, 1 bit: register file write strobe.
REQ-013 SHALL have port retire, output, 1 bit: one-cycle pulse per completed instruction.
REQ-014 SHALL have port instret, output, 32 bits: count of retired instructions.
REQ-015 SHALL have port trap, output, 1 bit: sticky fault indicator.

Function
REQ-016 SHALL implement states FETCH, DECODE, EXECUTE, WRITEBACK and TRAP.
REQ-017 FETCH SHALL assert imem_req with imem_addr=pc and hold both stable until imem_ready=1.
REQ-018 On imem_ready=1 in FETCH, SHALL load IR<=imem_rdata and go to DECODE; minimum latency is 4 cycles per instruction, with imem_ready in the same cycle as the request.
REQ-019 DECODE SHALL classify IR[6:0]: 0110011 reg, 0010011 imm, 1100011 branch, 1101111 jal, 1100111 jalr (requires funct3=000), 0110111 lui, 0010111 auipc.
REQ-020 Any other opcode, or jalr with funct3!=000, SHALL go from DECODE to TRAP.
REQ-021 EXECUTE SHALL assert exactly one enable for the decoded class, for one cycle; all enables are 0 in every other state.
REQ-022 WRITEBACK SHALL assert rd_write_enable for one cycle for every class except branch, and only when IR[11:7]!=0.
REQ-023 WRITEBACK SHALL update pc: next_pc when next_pc_valid=1 (sampled in WRITEBACK), otherwise pc+4, mod 2^32.
REQ-024 If the selected new pc has bits[1:0]!=00, SHALL go to TRAP with pc, rd_write_enable and instret unchanged.
REQ-025 Otherwise WRITEBACK SHALL pulse retire, increment instret (wraps from FFFF_FFFF to 0) and go to FETCH.
REQ-026 TRAP SHALL be absorbing until reset: trap=1, imem_req=0, all enables=0, pc and IR frozen.
REQ-027 imem_ready outside FETCH SHALL be ignored.

Reset
REQ-028 When reset_n=0 (asynchronous), SHALL set state=FETCH, pc=RESET_PC, IR=32'h0000_0013 (nop), instret=0, and all outputs except pc, imem_addr, instruction and instret to 0.
REQ-029 Reset asserted mid-fetch or mid-instruction SHALL abandon that instruction with no retire.
REQ-030 imem_req SHALL first assert in the first clock cycle after reset_n deasserts.

Structure
REQ-031 A shared package SHALL hold the state enum, the seven opcode constants, the NOP encoding and the PC increment (4).
REQ-032 A sub-module opcode_decoder SHALL be combinational: IR in, one-hot class plus illegal flag out.
REQ-033 The FSM, PC register, IR and instret counter SHALL reside in core_control_fsm.

Verification
REQ-034 Reset with RESET_PC=0x100 and imem_ready held 1, fetch addi x1,x0,5 (0x00500093) -> imm enable in cycle 3, rd_write_enable in cycle 4, pc=0x104, instret=1.
REQ-035 imem_ready held 0 for 5 cycles -> imem_req=1 and imem_addr constant throughout; IR loads only on the ready cycle.
REQ-036 beq with next_pc_valid=1, next_pc=0x200 -> rd_write_enable=0, pc=0x200, retire pulse.
REQ-037 Opcode 0000011 (load) -> trap=1 after DECODE, imem_req=0 thereafter, instret unchanged.
REQ-038 jal with next_pc=0x102 -> trap=1, pc unchanged.
REQ-039 instret preloaded to FFFF_FFFF (by forcing the counter), then one retire -> instret=0; reset_n pulsed low mid-EXECUTE -> pc=RESET_PC immediately and no retire.

Source files
------------

// File: rtl/core_control_fsm_pkg.sv
// Shared definitions for the core control FSM: state encoding, RV32I opcode
// constants, instruction-class indices, the reset NOP and the PC step.
package core_control_fsm_pkg;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXECUTE,
      WRITEBACK,
      TRAP
   } state_t;

   localparam logic [6:0] OPC_REG    = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // Bit positions in the one-hot class vector; the order matches the
   // enable-port concatenation in the top level.
   localparam int NUM_CLASSES = 7;
   localparam int CLS_AUIPC   = 0;
   localparam int CLS_LUI     = 1;
   localparam int CLS_JALR    = 2;
   localparam int CLS_JAL     = 3;
   localparam int CLS_BRANCH  = 4;
   localparam int CLS_IMM     = 5;
   localparam int CLS_REG     = 6;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/core_control_fsm_opcode_decoder.sv
// Combinational instruction classifier: maps the IR opcode (and jalr funct3)
// to a one-hot class vector, flagging anything unsupported as illegal.
module opcode_decoder
   import core_control_fsm_pkg::*;
(
   input  logic [6:0]             opcode,
   input  logic [2:0]             funct3,
   output logic [NUM_CLASSES-1:0] op_class,
   output logic                   illegal
);

   always_comb begin
      op_class = '0;
      illegal  = 1'b0;
      case (opcode)
         OPC_REG:    op_class[CLS_REG]    = 1'b1;
         OPC_IMM:    op_class[CLS_IMM]    = 1'b1;
         OPC_BRANCH: op_class[CLS_BRANCH] = 1'b1;
         OPC_JAL:    op_class[CLS_JAL]    = 1'b1;
         OPC_JALR: begin
            if (funct3 == 3'b000) op_class[CLS_JALR] = 1'b1;
            else                  illegal            = 1'b1;
         end
         OPC_LUI:    op_class[CLS_LUI]    = 1'b1;
         OPC_AUIPC:  op_class[CLS_AUIPC]  = 1'b1;
         default:    illegal              = 1'b1;
      endcase
   end

endmodule

// File: rtl/core_control_fsm.sv
// Multi-cycle control FSM: fetch, decode, execute, writeback with a sticky
// trap state; owns the PC, instruction register and retired-instruction count.
module core_control_fsm
   import core_control_fsm_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] pc,
   output logic        register_type_alu,
   output logic        immediate_type_alu,
   output logic        branch_enable,
   output logic        jal_enable,
   output logic        jalr_enable,
   output logic        lui_enable,
   output logic        auipc_enable,
   input  logic        next_pc_valid,
   input  logic [31:0] next_pc,
   output logic        rd_write_enable,
   output logic        retire,
   output logic [31:0] instret,
   output logic        trap
);

   state_t                 state_q, state_d;
   logic [31:0]            pc_q;
   logic [31:0]            ir_q;
   logic [31:0]            instret_q;
   logic [NUM_CLASSES-1:0] op_class;
   logic                   illegal;
   logic [31:0]            new_pc;
   logic                   misaligned;
   logic                   has_rd;

   opcode_decoder u_opcode_decoder (
      .opcode   (ir_q[6:0]),
      .funct3   (ir_q[14:12]),
      .op_class (op_class),
      .illegal  (illegal)
   );

   assign new_pc     = next_pc_valid ? next_pc : pc_q + PC_INC;
   assign misaligned = (new_pc[1:0] != 2'b00);
   assign has_rd     = (ir_q[11:7] != 5'd0);

   always_comb begin
      state_d            = state_q;
      imem_req           = 1'b0;
      register_type_alu  = 1'b0;
      immediate_type_alu = 1'b0;
      branch_enable      = 1'b0;
      jal_enable         = 1'b0;
      jalr_enable        = 1'b0;
      lui_enable         = 1'b0;
      auipc_enable       = 1'b0;
      rd_write_enable    = 1'b0;
      retire             = 1'b0;
      trap               = 1'b0;
      case (state_q)
         FETCH: begin
            // Gated so the request stays low while reset is held.
            imem_req = reset_n;
            if (imem_ready) state_d = DECODE;
         end
         DECODE: begin
            state_d = illegal ? TRAP : EXECUTE;
         end
         EXECUTE: begin
            {register_type_alu, immediate_type_alu, branch_enable, jal_enable,
             jalr_enable, lui_enable, auipc_enable} = op_class;
            state_d = WRITEBACK;
         end
         WRITEBACK: begin
            if (misaligned) begin
               state_d = TRAP;
            end else begin
               retire          = 1'b1;
               rd_write_enable = has_rd && !op_class[CLS_BRANCH];
               state_d         = FETCH;
            end
         end
         TRAP: begin
            trap = 1'b1;
         end
         default: begin
            state_d = TRAP;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= NOP;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == FETCH && imem_ready) ir_q <= imem_rdata;
         // retire is only high on an aligned writeback, so a trap freezes both.
         if (retire) begin
            pc_q      <= new_pc;
            instret_q <= instret_q + 32'd1;
         end
      end
   end

   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instruction = ir_q;
   assign instret     = instret_q;

endmodule

// File: tb/tb_core_control_fsm.sv
// Self-checking bench for core_control_fsm: directed scenarios followed by a
// random instruction stream, checked against a per-instruction reference model.
module tb_core_control_fsm;

   localparam logic [31:0] RPC  = 32'h0000_0100;
   localparam logic [31:0] NOPW = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        register_type_alu, immediate_type_alu, branch_enable;
   logic        jal_enable, jalr_enable, lui_enable, auipc_enable;
   logic        next_pc_valid = 1'b0;
   logic [31:0] next_pc = '0;
   logic        rd_write_enable;
   logic        retire;
   logic [31:0] instret;
   logic        trap;
   logic [6:0]  en_vec;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   logic [31:0] m_pc, m_ir, m_instret;
   logic        m_trap;

   core_control_fsm #(.RESET_PC(RPC)) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .imem_req           (imem_req),
      .imem_addr          (imem_addr),
      .imem_ready         (imem_ready),
      .imem_rdata         (imem_rdata),
      .instruction        (instruction),
      .pc                 (pc),
      .register_type_alu  (register_type_alu),
      .immediate_type_alu (immediate_type_alu),
      .branch_enable      (branch_enable),
      .jal_enable         (jal_enable),
      .jalr_enable        (jalr_enable),
      .lui_enable         (lui_enable),
      .auipc_enable       (auipc_enable),
      .next_pc_valid      (next_pc_valid),
      .next_pc            (next_pc),
      .rd_write_enable    (rd_write_enable),
      .retire             (retire),
      .instret            (instret),
      .trap               (trap)
   );

   always #5 clock = ~clock;

   assign en_vec = {register_type_alu, immediate_type_alu, branch_enable,
                    jal_enable, jalr_enable, lui_enable, auipc_enable};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Instruction class from the opcode rules; -1 means illegal.
   // 6=reg 5=imm 4=branch 3=jal 2=jalr 1=lui 0=auipc (enable-vector bit).
   function automatic int classify(input logic [31:0] w);
      case (w[6:0])
         7'b0110011: return 6;
         7'b0010011: return 5;
         7'b1100011: return 4;
         7'b1101111: return 3;
         7'b1100111: return (w[14:12] == 3'b000) ? 2 : -1;
         7'b0110111: return 1;
         7'b0010111: return 0;
         default:    return -1;
      endcase
   endfunction

   task automatic model_reset();
      m_pc = RPC; m_ir = NOPW; m_instret = 0; m_trap = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      imem_ready = 1'b1;
      #1;
      chk("rst_pc", pc, RPC);
      chk("rst_addr", imem_addr, RPC);
      chk("rst_instret", instret, 32'd0);
      chk("rst_ir", instruction, NOPW);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_trap", 32'(trap), 32'd0);
      chk("rst_en", 32'(en_vec), 32'd0);
      chk("rst_retire", 32'(retire), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      #1;
      chk("req_after_rst", 32'(imem_req), 32'd1);
   endtask

   task automatic trap_checks(input int n);
      for (int i = 0; i < n; i++) begin
         imem_ready = 1'($urandom);
         imem_rdata = $urandom;
         next_pc_valid = 1'($urandom);
         next_pc = $urandom;
         #1;
         chk("trap_flag", 32'(trap), 32'd1);
         chk("trap_req", 32'(imem_req), 32'd0);
         chk("trap_en", 32'(en_vec), 32'd0);
         chk("trap_pc", pc, m_pc);
         chk("trap_ir", instruction, m_ir);
         chk("trap_instret", instret, m_instret);
         chk("trap_rdwe", 32'(rd_write_enable), 32'd0);
         @(negedge clock);
      end
   endtask

   task automatic run_instr(input logic [31:0] word, input int delay,
                            input logic npv, input logic [31:0] npc, input bit abort_exec);
      int          cls;
      logic [31:0] newpc;
      logic        mis;
      cls = classify(word);
      for (int k = 0; k <= delay; k++) begin
         imem_ready = (k == delay);
         imem_rdata = (k == delay) ? word : $urandom;
         next_pc_valid = 1'($urandom);
         next_pc = $urandom;
         #1;
         chk("fetch_req", 32'(imem_req), 32'd1);
         chk("fetch_addr", imem_addr, m_pc);
         chk("fetch_ir_hold", instruction, m_ir);
         chk("fetch_en", 32'(en_vec), 32'd0);
         @(negedge clock);
      end
      m_ir = word;
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      #1;
      chk("dec_req", 32'(imem_req), 32'd0);
      chk("dec_ir", instruction, word);
      chk("dec_en", 32'(en_vec), 32'd0);
      @(negedge clock);
      if (cls < 0) begin
         m_trap = 1'b1;
         trap_checks(3);
         return;
      end
      imem_ready = 1'($urandom);
      #1;
      chk("exec_en", 32'(en_vec), 32'd1 << cls);
      chk("exec_req", 32'(imem_req), 32'd0);
      chk("exec_rdwe", 32'(rd_write_enable), 32'd0);
      if (abort_exec) begin
         reset_n = 1'b0;
         #1;
         chk("abort_pc", pc, RPC);
         chk("abort_retire", 32'(retire), 32'd0);
         chk("abort_en", 32'(en_vec), 32'd0);
         chk("abort_instret", instret, 32'd0);
         @(negedge clock);
         chk("abort_hold_retire", 32'(retire), 32'd0);
         reset_n = 1'b1;
         model_reset();
         #1;
         chk("abort_req", 32'(imem_req), 32'd1);
         return;
      end
      @(negedge clock);
      next_pc_valid = npv;
      next_pc = npc;
      imem_ready = 1'($urandom);
      #1;
      newpc = npv ? npc : m_pc + 32'd4;
      mis = (newpc[1:0] != 2'b00);
      chk("wb_rdwe", 32'(rd_write_enable), 32'(!mis && cls != 4 && word[11:7] != 5'd0));
      chk("wb_retire", 32'(retire), 32'(!mis));
      chk("wb_en", 32'(en_vec), 32'd0);
      @(negedge clock);
      if (mis) begin
         m_trap = 1'b1;
      end else begin
         m_pc = newpc;
         m_instret = m_instret + 32'd1;
      end
      chk("post_pc", pc, m_pc);
      chk("post_instret", instret, m_instret);
      chk("post_retire", 32'(retire), 32'd0);
      if (m_trap) trap_checks(2);
   endtask

   initial begin
      logic [6:0]  opc_tab [8];
      logic [31:0] w;
      logic [31:0] npc;
      opc_tab = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                  7'b1100111, 7'b0110111, 7'b0010111, 7'b0000011};
      model_reset();
      @(negedge clock);
      do_reset();

      // addi x1,x0,5 straight after reset with ready held high
      run_instr(32'h0050_0093, 0, 1'b0, 32'h0, 1'b0);
      chk("addi_pc", pc, 32'h0000_0104);
      chk("addi_instret", instret, 32'd1);

      // five wait cycles before ready
      run_instr(32'h00A0_0113, 5, 1'b0, 32'h0, 1'b0);

      // taken branch to 0x200: no register write
      run_instr(32'h0020_8463, 1, 1'b1, 32'h0000_0200, 1'b0);
      chk("beq_pc", pc, 32'h0000_0200);

      // instret wrap from all-ones
      force dut.instret_q = 32'hFFFF_FFFF;
      #1;
      release dut.instret_q;
      m_instret = 32'hFFFF_FFFF;
      chk("forced_instret", instret, 32'hFFFF_FFFF);
      run_instr(32'h0020_81B3, 0, 1'b0, 32'h0, 1'b0);
      chk("wrap_instret", instret, 32'd0);

      // reset mid-execute abandons the instruction
      run_instr(32'h1234_52B7, 0, 1'b0, 32'h0, 1'b1);

      // jal to a misaligned target traps with pc frozen
      run_instr(32'h0080_00EF, 0, 1'b1, 32'h0000_0102, 1'b0);
      chk("jal_mis_pc", pc, RPC);
      do_reset();

      // load opcode is illegal
      run_instr(32'h0000_2083, 2, 1'b0, 32'h0, 1'b0);
      chk("load_instret", instret, 32'd0);
      do_reset();

      // jalr with nonzero funct3 is illegal
      run_instr(32'h0000_10E7, 0, 1'b0, 32'h0, 1'b0);
      do_reset();

      // random instruction stream
      for (int i = 0; i < 80; i++) begin
         w = $urandom;
         w[6:0] = opc_tab[$urandom_range(0, 7)];
         if (w[6:0] == 7'b1100111 && $urandom_range(0, 3) != 0) w[14:12] = 3'b000;
         npc = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) npc[1:0] = 2'($urandom_range(1, 3));
         run_instr(w, $urandom_range(0, 3), 1'($urandom), npc, 1'b0);
         if (m_trap) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
